// File: rtl/code_sequencer.sv
// code_sequencer: runs a small stored program of op codes line by line,
// counting cycles per line and epochs per run, under controller requests.
module code_sequencer #(
    parameter int unsigned op_size    = 4,
    parameter int unsigned code_depth = 8,
    parameter int unsigned epoch_init = 3,
    localparam int unsigned AW = (code_depth > 1) ? $clog2(code_depth) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               prog_we,
    input  logic [AW-1:0]      prog_addr,
    input  logic [op_size-1:0] prog_op,
    input  logic               count_reset,
    input  logic               code_active,
    input  logic               code_reset,
    output logic [op_size-1:0] op,
    output logic [31:0]        code_count,
    output logic [31:0]        code_index,
    output logic [31:0]        epoch_left,
    output logic               busy,
    output logic               done
);

    localparam int unsigned LAST = code_depth - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [op_size-1:0] r_mem [code_depth];
    logic [op_size-1:0] r_op;
    logic [op_size-1:0] w_op_nxt;
    logic [31:0]        r_code_count;
    logic [31:0]        w_count_nxt;
    logic [31:0]        r_code_index;
    logic [31:0]        w_index_nxt;
    logic [31:0]        r_epoch_left;
    logic [31:0]        w_epoch_nxt;
    logic [31:0]        w_adv_idx;
    logic               r_busy;
    logic               r_done;
    logic               r_active_q;
    logic               r_creset_q;
    logic               w_active_rise;
    logic               w_creset_rise;

    assign w_active_rise = code_active & ~r_active_q;
    assign w_creset_rise = code_reset & ~r_creset_q;
    assign w_adv_idx     = (r_code_index == 32'(LAST)) ? 32'd0 : r_code_index + 32'd1;

    // Program memory: writable only while not running; untouched by reset.
    always_ff @(posedge clk) begin
        if (!reset && prog_we && (r_state != S_RUN)) begin
            r_mem[prog_addr] <= prog_op;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next datapath values; code_reset beats code_active beats count_reset.
    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_code_index;
        w_count_nxt = r_code_count;
        w_epoch_nxt = r_epoch_left;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_index_nxt = 32'd0;
                    w_count_nxt = 32'd0;
                    w_epoch_nxt = 32'(epoch_init);
                    w_state_nxt = (r_mem[0] == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_creset_rise) begin
                    w_index_nxt = 32'd0;
                    w_count_nxt = 32'd0;
                    if (r_epoch_left <= 32'd1) begin
                        w_epoch_nxt = 32'd0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_epoch_nxt = r_epoch_left - 32'd1;
                        if (r_mem[0] == '0) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end else if (w_active_rise) begin
                    // Halt on an op-0 line: stay on the current line and stop.
                    if (r_mem[w_adv_idx[AW-1:0]] == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_index_nxt = w_adv_idx;
                        w_count_nxt = 32'd0;
                    end
                end else if (count_reset) begin
                    w_count_nxt = 32'd0;
                end else if (r_code_count != 32'hFFFF_FFFF) begin
                    w_count_nxt = r_code_count + 32'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_op_nxt = (w_state_nxt == S_RUN) ? r_mem[w_index_nxt[AW-1:0]] : '0;
    end

    // Registered datapath, status flags and edge-detect history.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op         <= '0;
            r_code_count <= 32'd0;
            r_code_index <= 32'd0;
            r_epoch_left <= 32'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_active_q   <= 1'b0;
            r_creset_q   <= 1'b0;
        end else begin
            r_op         <= w_op_nxt;
            r_code_count <= w_count_nxt;
            r_code_index <= w_index_nxt;
            r_epoch_left <= w_epoch_nxt;
            r_busy       <= (w_state_nxt == S_RUN);
            r_done       <= (w_state_nxt == S_DONE);
            r_active_q   <= code_active;
            r_creset_q   <= code_reset;
        end
    end

    assign op         = r_op;
    assign code_count = r_code_count;
    assign code_index = r_code_index;
    assign epoch_left = r_epoch_left;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_code_sequencer.sv
// Directed bench for code_sequencer: expected outputs are queued as each
// step is driven and checked one cycle later, just after the clock edge.
module tb_code_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        prog_we;
    logic [2:0]  prog_addr;
    logic [3:0]  prog_op;
    logic        count_reset;
    logic        code_active;
    logic        code_reset;
    logic [3:0]  op;
    logic [31:0] code_count;
    logic [31:0] code_index;
    logic [31:0] epoch_left;
    logic        busy;
    logic        done;

    typedef struct {
        string       tag;
        logic [31:0] op;
        logic [31:0] cnt;
        logic [31:0] idx;
        logic [31:0] ep;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [3:0]  model_mem [8];

    code_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_op     (prog_op),
        .count_reset (count_reset),
        .code_active (code_active),
        .code_reset  (code_reset),
        .op          (op),
        .code_count  (code_count),
        .code_index  (code_index),
        .epoch_left  (epoch_left),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, exp);
        end
    endtask

    // Advance one clock edge, then drain the scoreboard against the outputs.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, "op",    32'(op),    e.op);
            chk(e.tag, "count", code_count, e.cnt);
            chk(e.tag, "index", code_index, e.idx);
            chk(e.tag, "epoch", epoch_left, e.ep);
            chk(e.tag, "busy",  32'(busy),  32'(e.busy));
            chk(e.tag, "done",  32'(done),  32'(e.done));
        end
    endtask

    task automatic step(input string tag, input int o, input int c, input int i,
                        input int ep, input logic b, input logic d);
        exp_t e;
        e.tag  = tag;
        e.op   = 32'(o);
        e.cnt  = 32'(c);
        e.idx  = 32'(i);
        e.ep   = 32'(ep);
        e.busy = b;
        e.done = d;
        sb.push_back(e);
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = 3'd0; prog_op = 4'd0;
        count_reset = 1'b0; code_active = 1'b0; code_reset = 1'b0;
        model_mem = '{4'd1, 4'd1, 4'd2, 4'd0, 4'd5, 4'd6, 4'd7, 4'd8};

        tick();
        step("reset", 0, 0, 0, 0, 1'b0, 1'b0);
        reset = 1'b0;

        // Load program {1,1,2,0,5,6,7,8}
        for (int a = 0; a < 8; a++) begin
            prog_we = 1'b1; prog_addr = 3'(a); prog_op = model_mem[a];
            tick();
        end
        prog_we = 1'b0;
        step("idle_after_prog", 0, 0, 0, 0, 1'b0, 1'b0);

        // Start and free-run counting
        start = 1'b1;
        step("start", 1, 0, 0, 3, 1'b1, 1'b0);
        start = 1'b0;
        for (int c = 1; c <= 5; c++) step("count_run", 1, c, 0, 3, 1'b1, 1'b0);

        // code_active held four cycles advances exactly once
        code_active = 1'b1;
        step("adv_rise", 1, 0, 1, 3, 1'b1, 1'b0);
        for (int c = 1; c <= 3; c++) step("adv_hold", 1, c, 1, 3, 1'b1, 1'b0);
        code_active = 1'b0;
        step("adv_release", 1, 4, 1, 3, 1'b1, 1'b0);

        // count_reset held three cycles
        count_reset = 1'b1;
        for (int k = 0; k < 3; k++) step("count_reset_hold", 1, 0, 1, 3, 1'b1, 1'b0);
        count_reset = 1'b0;
        step("count_reset_release", 1, 1, 1, 3, 1'b1, 1'b0);

        // start and a memory write during RUN are ignored
        start = 1'b1; prog_we = 1'b1; prog_addr = 3'd1; prog_op = 4'hF;
        step("start_in_run", 1, 2, 1, 3, 1'b1, 1'b0);
        start = 1'b0; prog_we = 1'b0;
        step("after_start_in_run", 1, 3, 1, 3, 1'b1, 1'b0);

        // Epoch 1 ends
        code_reset = 1'b1;
        step("epoch_pulse1", 1, 0, 0, 2, 1'b1, 1'b0);
        code_reset = 1'b0;
        step("epoch_pulse1_rel", 1, 1, 0, 2, 1'b1, 1'b0);
        code_active = 1'b1;
        step("adv_line1", 1, 0, 1, 2, 1'b1, 1'b0);
        code_active = 1'b0;
        step("adv_line1_rel", 1, 1, 1, 2, 1'b1, 1'b0);

        // Simultaneous code_reset and code_active: code_reset wins
        code_reset = 1'b1; code_active = 1'b1;
        step("both_rise", 1, 0, 0, 1, 1'b1, 1'b0);
        code_reset = 1'b0; code_active = 1'b0;
        step("both_rise_rel", 1, 1, 0, 1, 1'b1, 1'b0);

        // Final epoch ends the run
        code_reset = 1'b1;
        step("epoch_last", 0, 0, 0, 0, 1'b0, 1'b1);
        code_reset = 1'b0;
        step("done_hold", 0, 0, 0, 0, 1'b0, 1'b1);
        code_active = 1'b1; count_reset = 1'b1;
        step("done_ignores_ctl", 0, 0, 0, 0, 1'b0, 1'b1);
        code_active = 1'b0; count_reset = 1'b0;

        // Restart from DONE and halt on the op-0 line
        start = 1'b1;
        step("restart", 1, 0, 0, 3, 1'b1, 1'b0);
        start = 1'b0;
        step("restart_cnt", 1, 1, 0, 3, 1'b1, 1'b0);
        for (int l = 1; l <= 2; l++) begin
            code_active = 1'b1;
            step("walk", model_mem[l], 0, l, 3, 1'b1, 1'b0);
            code_active = 1'b0;
            step("walk_rel", model_mem[l], 1, l, 3, 1'b1, 1'b0);
        end
        code_active = 1'b1;
        step("halt_op0", 0, 1, 2, 3, 1'b0, 1'b1);
        code_active = 1'b0;
        step("halt_hold", 0, 1, 2, 3, 1'b0, 1'b1);

        // Reprogram line 3 in DONE, then walk all lines and wrap
        prog_we = 1'b1; prog_addr = 3'd3; prog_op = 4'd4;
        model_mem[3] = 4'd4;
        step("prog_in_done", 0, 1, 2, 3, 1'b0, 1'b1);
        prog_we = 1'b0;
        start = 1'b1;
        step("start_wrap_run", 1, 0, 0, 3, 1'b1, 1'b0);
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            code_active = 1'b1;
            step("wrap_adv", model_mem[k % 8], 0, k % 8, 3, 1'b1, 1'b0);
            code_active = 1'b0;
            step("wrap_adv_rel", model_mem[k % 8], 1, k % 8, 3, 1'b1, 1'b0);
        end

        // Reset mid-run aborts; memory survives
        reset = 1'b1;
        step("reset_mid_run", 0, 0, 0, 0, 1'b0, 1'b0);
        reset = 1'b0;
        step("idle_after_reset", 0, 0, 0, 0, 1'b0, 1'b0);
        start = 1'b1;
        step("start_after_reset", 1, 0, 0, 3, 1'b1, 1'b0);
        start = 1'b0;
        code_active = 1'b1;
        step("mem_kept_line1", 1, 0, 1, 3, 1'b1, 1'b0);
        code_active = 1'b0;
        step("mem_kept_line1_rel", 1, 1, 1, 3, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/code_sequencer.md
CODE_SEQUENCER -- requirements
Module: code_sequencer

Interface
REQ-001 Parameter op_size, default 4, width of the op field.
REQ-002 Parameter code_depth, default 8, number of program lines.
REQ-003 Parameter epoch_init, default 3, number of epochs per run.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 reset  input  1  synchronous, active-high block reset.
REQ-006 start  input  1  one-cycle pulse; begins a run.
REQ-007 prog_we  input  1  program write strobe.
REQ-008 prog_addr  input  $clog2(code_depth)  program line to write.
REQ-009 prog_op  input  op_size  op code written to that line.
REQ-010 count_reset  input  1  controller request to clear code_count.
REQ-011 code_active  input  1  controller request to advance to the next line.
REQ-012 code_reset  input  1  controller request to restart at line 0 and end the epoch.
REQ-013 op  output  op_size  op code of the current line.
REQ-014 code_count  output  32  cycles elapsed within the current line.
REQ-015 code_index  output  32  current line number.
REQ-016 epoch_left  output  32  epochs remaining.
REQ-017 busy  output  1  high in RUN.
REQ-018 done  output  1  high in DONE.

Function
REQ-019 States are IDLE, RUN and DONE; all outputs are registered.
REQ-020 Program memory holds code_depth entries of op_size bits.
REQ-021 prog_we writes prog_op to prog_addr at the clock edge in IDLE or DONE; writes are ignored in RUN.
REQ-022 start in IDLE or DONE enters RUN with code_index=0, code_count=0 and epoch_left=epoch_init; start in RUN is ignored.
REQ-023 In RUN, op = mem[code_index]; in IDLE and DONE, op = 0.
REQ-024 In RUN, code_count increments by 1 every cycle and saturates at 2^32-1 (no wrap).
REQ-025 count_reset is level-sensitive: every cycle it is sampled high in RUN, code_count = 0 on the next edge.
REQ-026 code_active is edge-detected: a sampled 0->1 transition advances the line once; holding it high does not advance further.
REQ-027 A line advance sets code_index+1 and code_count=0.
REQ-028 Advancing from line code_depth-1 wraps code_index to 0; epoch_left is not changed.
REQ-029 code_reset is edge-detected: its rising edge sets code_index=0, code_count=0 and epoch_left-1.
REQ-030 If a code_reset rising edge occurs while epoch_left==1, epoch_left becomes 0 and the block enters DONE.
REQ-031 When code_reset and code_active rising edges occur in the same cycle, code_reset takes priority and code_active is discarded.
REQ-032 A line advance takes priority over count_reset; code_count is 0 in either case.
REQ-033 If the line being entered holds op 0, the block enters DONE instead of running that line (halt).
REQ-034 In DONE, code_index and code_count hold their last values, and epoch_left holds.
REQ-035 count_reset, code_active and code_reset are ignored outside RUN; the edge-detect history still updates.

Reset
REQ-036 reset has priority over every other input; after it: state=IDLE, op=0, code_count=0, code_index=0, epoch_left=0, busy=0, done=0, and the edge-detect history is 0.
REQ-037 The program memory contents are unaffected by reset.
REQ-038 reset during RUN aborts the run; a new start is required to resume.

Verification
REQ-039 Load ops {1,1,2,0}, then start -> busy=1, op=1, code_index=0, and code_count goes 0,1,2,... on successive cycles.
REQ-040 code_active held high 4 cycles starting at code_count=5 -> code_index=1 and code_count=0 exactly once, then code_count counts 1,2,3.
REQ-041 count_reset held 3 cycles -> code_count stays 0 during those cycles and is 1 the cycle after release.
REQ-042 With epoch_init=3, three code_reset pulses -> epoch_left goes 2,1,0; after the third pulse done=1, busy=0 and op=0.
REQ-043 code_active at line 2 when line 3 holds op 0 -> DONE, with code_index=2 held.
REQ-044 code_reset and code_active rising in the same cycle -> code_index=0 and epoch_left decremented; a reset mid-run returns to IDLE and a prog_we during RUN leaves memory unchanged.
